multicycle_sequencer: RTL

- Multi-cycle control sequencer that steps the processor through FETCH/DECODE/EXEC/MEM/WB phases.
- Phase-gates the write-type controls (register write, data-memory write, PC update) so each instruction commits exactly once.
- Handles the start/done handshake with the testbench and a variable-latency data-memory ready signal.
- Sits between the control decoder (supplies opcode class) and the PC, instruction register, register file and data memory.

---
 rtl/multicycle_sequencer.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/multicycle_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control sequencer with phase-gated commit strobes,
// data-memory wait timeout and a retired-instruction counter.
module multicycle_sequencer #(
    parameter int                OPW       = 5,
    parameter logic [OPW-1:0]    OP_STORE  = 5'b00000,
    parameter logic [OPW-1:0]    OP_LOAD   = 5'b00010,
    parameter logic [OPW-1:0]    OP_BRANCH = 5'b00011,
    parameter logic [OPW-1:0]    OP_HALT   = 5'b11111,
    parameter int                CNTW      = 16,
    parameter int                MEM_TO    = 15
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start,
    input  logic [OPW-1:0]  opcode,
    input  logic            branch_taken,
    input  logic            mem_ready,
    output logic            pc_rst,
    output logic            ir_load,
    output logic            pc_inc,
    output logic            pc_load,
    output logic            reg_we,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic            done,
    output logic            err,
    output logic [2:0]      state,
    output logic [CNTW-1:0] instr_count
);

    // state  | meaning
    // IDLE   | after reset, waiting for start
    // FETCH  | load IR from instruction memory
    // DECODE | route by opcode class
    // EXEC   | ALU / branch resolution (branch commits here)
    // MEM    | data-memory access, waits for mem_ready (store commits here)
    // WB     | register write-back and PC increment
    // DONE   | halted, done held
    // ERROR  | memory timeout, done and err held
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_DONE   = 3'd6,
        S_ERROR  = 3'd7
    } state_t;

    localparam int WW = (MEM_TO < 2) ? 1 : $clog2(MEM_TO + 1);

    state_t          state_q, state_d;
    logic [WW-1:0]   wait_q, wait_d;
    logic [CNTW-1:0] count_q;
    logic            done_q, err_q;
    logic            restart;
    logic            is_mem_op;

    assign is_mem_op = (opcode == OP_LOAD) || (opcode == OP_STORE);

    always_comb begin
        state_d  = state_q;
        wait_d   = '0;
        restart  = 1'b0;
        pc_rst   = 1'b0;
        ir_load  = 1'b0;
        pc_inc   = 1'b0;
        pc_load  = 1'b0;
        reg_we   = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    pc_rst  = 1'b1;
                    restart = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                ir_load = 1'b1;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                if (opcode == OP_HALT)
                    state_d = S_DONE;
                else if (is_mem_op)
                    state_d = S_MEM;
                else
                    state_d = S_EXEC;
            end
            S_EXEC: begin
                if (opcode == OP_BRANCH) begin
                    pc_load = branch_taken;
                    pc_inc  = ~branch_taken;
                    state_d = S_FETCH;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                dmem_req = 1'b1;
                // a late ready still wins over the timeout in the final wait cycle
                if (mem_ready) begin
                    if (opcode == OP_STORE) begin
                        dmem_we = 1'b1;
                        pc_inc  = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (wait_q == WW'(MEM_TO - 1)) begin
                    state_d = S_ERROR;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            S_WB: begin
                reg_we  = 1'b1;
                pc_inc  = 1'b1;
                state_d = S_FETCH;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            wait_q  <= '0;
            count_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            done_q  <= (state_d == S_DONE) || (state_d == S_ERROR);
            err_q   <= (state_d == S_ERROR);
            if (restart)
                count_q <= '0;
            else if (pc_inc || pc_load)
                count_q <= count_q + 1'b1;
        end
    end

    assign state       = state_q;
    assign done        = done_q;
    assign err         = err_q;
    assign instr_count = count_q;

endmodule
